// File: rtl/mult_fu.sv
// Iterative shift-add RV32M multiplier feeding the CDB through a valid/grant handshake.
// Optional MULT_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_fu #(
  parameter int WIDTH    = 32,
  parameter int ROB_ID_W = 8,
  parameter int PREG_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    rs1_v,
  input  logic [WIDTH-1:0]    rs2_v,
  input  logic [ROB_ID_W-1:0] rob_id,
  input  logic [PREG_W-1:0]   pd,
  input  logic                flush,
  input  logic                cdb_grant,
  output logic                ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [PREG_W-1:0]   cdb_pd,
  output logic [WIDTH-1:0]    cdb_value
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_op;
  logic [ROB_ID_W-1:0]   r_rob_id;
  logic [PREG_W-1:0]     r_pd;
  logic [WIDTH-1:0]      r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic                  r_neg;
  logic [2*WIDTH-1:0]    r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cdb_valid;
  logic [ROB_ID_W-1:0]   r_cdb_rob_id;
  logic [PREG_W-1:0]     r_cdb_pd;
  logic [WIDTH-1:0]      r_cdb_value;

  logic                  w_rs1_neg;
  logic                  w_rs2_neg;
  logic [WIDTH-1:0]      w_rs1_abs;
  logic [WIDTH-1:0]      w_rs2_abs;
  logic [2*WIDTH-1:0]    w_addend;
  logic [2*WIDTH-1:0]    w_acc_next;
  logic [WIDTH-1:0]      w_mplier_next;
  logic [2*WIDTH-1:0]    w_product;
  logic [WIDTH-1:0]      w_result;
  logic                  w_last;

  // Magnitudes are taken as unsigned WIDTH-bit values, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
  assign w_rs1_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1_v[WIDTH-1];
  assign w_rs2_neg = (op == OP_MULH) && rs2_v[WIDTH-1];
  assign w_rs1_abs = w_rs1_neg ? -rs1_v : rs1_v;
  assign w_rs2_abs = w_rs2_neg ? -rs2_v : rs2_v;

  assign w_addend      = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
  assign w_acc_next    = r_acc + w_addend;
  assign w_mplier_next = r_mplier >> 1;
  assign w_product     = r_neg ? -w_acc_next : w_acc_next;
  assign w_result      = (r_op == OP_MUL) ? w_product[WIDTH-1:0] : w_product[2*WIDTH-1:WIDTH];

`ifdef MULT_EARLY_OUT_EN
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: default assignment first, so no path through this block leaves the output unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start)     w_state_next = S_CALC;
        S_CALC:  if (w_last)    w_state_next = S_DONE;
        S_DONE:  if (cdb_grant) w_state_next = S_IDLE;
        default:                w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_rob_id     <= '0;
      r_pd         <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_neg        <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_pd     <= '0;
      r_cdb_value  <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_rob_id <= rob_id;
            r_pd     <= pd;
            r_mcand  <= w_rs1_abs;
            r_mplier <= w_rs2_abs;
            r_neg    <= w_rs1_neg ^ w_rs2_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cdb_valid  <= 1'b1;
            r_cdb_value  <= w_result;
            r_cdb_rob_id <= r_rob_id;
            r_cdb_pd     <= r_pd;
          end
        end
        S_DONE: begin
          if (cdb_grant) r_cdb_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_pd     = r_cdb_pd;
  assign cdb_value  = r_cdb_value;

endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: transaction-level model compared every cycle, plus directed literal checks.
module tb_mult_fu;

  localparam int W  = 32;
  localparam int RW = 8;
  localparam int PW = 6;
`ifdef MULT_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rs1_v;
  logic [W-1:0]  rs2_v;
  logic [RW-1:0] rob_id;
  logic [PW-1:0] pd;
  logic          flush;
  logic          cdb_grant;
  logic          ready;
  logic          cdb_valid;
  logic [RW-1:0] cdb_rob_id;
  logic [PW-1:0] cdb_pd;
  logic [W-1:0]  cdb_value;

  int n_tests = 0;
  int n_fail  = 0;

  mult_fu #(.WIDTH(W), .ROB_ID_W(RW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .rob_id(rob_id), .pd(pd), .flush(flush), .cdb_grant(cdb_grant), .ready(ready),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd), .cdb_value(cdb_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product: sign-extend per opcode, multiply on 2W bits, pick the half.
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = (o == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Cycles from the start cycle to the first cycle with cdb_valid high.
  function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int hb, early;
    mag = (o == 2'b01 && b[W-1]) ? -b : b;
    hb  = -1;
    for (int i = 0; i < W; i++) if (mag[i]) hb = i;
    early = 1 + (((hb + 1) > 1) ? (hb + 1) : 1);
    return EO ? early : (W + 1);
  endfunction

  // Transaction-level model: 0 idle, 1 busy, 2 presenting a result.
  int            m_st;
  int            m_remain;
  logic [W-1:0]  m_val;
  logic [RW-1:0] m_rob;
  logic [PW-1:0] m_pd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st     <= 0;
      m_remain <= 0;
      m_val    <= '0;
      m_rob    <= '0;
      m_pd     <= '0;
    end else if (flush) begin
      m_st <= 0;
    end else begin
      case (m_st)
        0: if (start) begin
          m_st     <= 1;
          m_remain <= ref_latency(op, rs2_v) - 1;
          m_val    <= ref_result(op, rs1_v, rs2_v);
          m_rob    <= rob_id;
          m_pd     <= pd;
        end
        1: begin
          m_remain <= m_remain - 1;
          if (m_remain == 1) m_st <= 2;
        end
        2: if (cdb_grant) m_st <= 0;
        default: m_st <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("cyc_ready", ready, (m_st == 0));
      check("cyc_valid", cdb_valid, (m_st == 2));
      if (m_st == 2) begin
        check("cyc_value", cdb_value, m_val);
        check("cyc_rob", cdb_rob_id, m_rob);
        check("cyc_pd", cdb_pd, m_pd);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW-1:0] rid, input logic [PW-1:0] p);
    @(negedge clk);
    start = 1'b1; op = o; rs1_v = a; rs2_v = b; rob_id = rid; pd = p;
    @(negedge clk);
    start = 1'b0; op = 2'b11; rs1_v = 32'hDEAD_BEEF; rs2_v = 32'h0BAD_F00D; rob_id = 8'hEE; pd = 6'h3F;
  endtask

  // Called at the negedge of cycle t+1; returns at the negedge of the first valid cycle.
  task automatic wait_valid(input string name, input int k0, input int exp_lat);
    int k;
    k = k0;
    while (!cdb_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_lat"}, k, exp_lat);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [RW-1:0] rid, input logic [PW-1:0] p,
                     input logic [W-1:0] exp_val, input int lat_off, input int lat_on);
    cdb_grant = 1'b1;
    issue(o, a, b, rid, p);
    wait_valid(name, 1, EO ? lat_on : lat_off);
    check({name, "_value"}, cdb_value, exp_val);
    check({name, "_rob"}, cdb_rob_id, rid);
    check({name, "_pd"}, cdb_pd, p);
    @(negedge clk);
    check({name, "_valid_drop"}, cdb_valid, 1'b0);
    check({name, "_ready_back"}, ready, 1'b1);
  endtask

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    int           lat_on;
  } vec_t;

  vec_t vecs[4];
  logic seen_valid;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
    op = 2'b00; rs1_v = '0; rs2_v = '0; rob_id = '0; pd = '0;
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_rob", cdb_rob_id, 8'h00);
    check("rst_pd", cdb_pd, 6'h00);
    check("rst_value", cdb_value, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // MUL 7 * -3 with grant held high.
    run("mul_neg", 2'b00, 32'd7, 32'hFFFF_FFFD, 8'h12, 6'd5, 32'hFFFF_FFEB, 33, 33);

    vecs[0] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 2};
    for (int i = 0; i < 4; i++)
      run($sformatf("hi%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, 8'(8'h20 + i), 6'(i + 1),
          vecs[i].r, 33, vecs[i].lat_on);

    // Backpressure: hold the result for five cycles before granting.
    cdb_grant = 1'b0;
    issue(2'b11, 32'h0001_0000, 32'h0003_0000, 8'h21, 6'd9);
    wait_valid("bp", 1, EO ? 19 : 33);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", cdb_valid, 1'b1);
      check("bp_hold_ready", ready, 1'b0);
      check("bp_hold_value", cdb_value, 32'h0000_0003);
      check("bp_hold_rob", cdb_rob_id, 8'h21);
      check("bp_hold_pd", cdb_pd, 6'd9);
      @(negedge clk);
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", cdb_valid, 1'b0);
    check("bp_ready_back", ready, 1'b1);

    // A second start while busy must not disturb the in-flight multiply.
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 8'h12, 6'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; rs1_v = 32'd5; rs2_v = 32'd6; rob_id = 8'h33; pd = 6'd7;
    @(negedge clk);
    start = 1'b0;
    wait_valid("busy_start", 5, 33);
    check("busy_start_rob", cdb_rob_id, 8'h12);
    check("busy_start_value", cdb_value, 32'hFFFF_FFEB);
    check("busy_start_pd", cdb_pd, 6'd5);
    @(negedge clk);

    // Flush at t+10 together with a start that must be ignored.
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 8'h44, 6'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; rob_id = 8'h55; rs1_v = 32'd2; rs2_v = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_ready", ready, 1'b1);
    check("flush_valid", cdb_valid, 1'b0);
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (cdb_valid) seen_valid = 1'b1;
    end
    check("flush_never_valid", seen_valid, 1'b0);

    // Asynchronous reset between clock edges mid-calculation.
    issue(2'b00, 32'd9, 32'hF000_0009, 8'h66, 6'd4);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", ready, 1'b1);
    check("arst_valid", cdb_valid, 1'b0);
    check("arst_value", cdb_value, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 2'b00, 32'd3, 32'd4, 8'h01, 6'd2, 32'd12, 33, 4);

    // Zero and small multipliers exercise the early-out path when enabled.
    run("rs2_zero", 2'b00, 32'h0000_1234, 32'h0, 8'h02, 6'd3, 32'h0, 33, 2);
    run("rs2_five", 2'b00, 32'h0000_1234, 32'h5, 8'h03, 6'd4, 32'h0000_5B04, 33, 4);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
